// File: rtl/protected_adder_pipeline_pkg.sv
// Shared constants and helpers for the parity-protected adder pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package protected_adder_pipeline_pkg;

    // Deepest pipeline the err_layer encoding can address.
    localparam int MAX_LAYERS  = 16;
    localparam int ERR_LAYER_W = 4;

    // Even parity of a word. Callers zero-extend to 64 bits; leading zeros do not change the parity.
    function automatic logic parity_of(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/protected_adder_pipeline_parity_stage_reg.sv
// One pipeline word register with a stored even-parity bit and a live parity check.
// Latency: 1 cycle from d to q when not held.
// Backpressure: none; hold freezes the contents and the upstream value is dropped.
module parity_stage_reg
    import protected_adder_pipeline_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             inject,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             mismatch
);

    logic [WIDTH-1:0] data_q;
    logic             par_q;

    // Capture the word unless held. Parity is taken before the optional bit-0 flip,
    // so an injected flip shows up as a mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            par_q  <= 1'b0;
        end else if (!hold) begin
            data_q <= d ^ WIDTH'(inject);
            par_q  <= parity_of(64'(d));
        end
    end

    // Recompute parity on the stored word and compare it to the stored bit.
    always_comb begin
        mismatch = parity_of(64'(data_q)) ^ par_q;
    end

    assign q = data_q;

endmodule

// File: rtl/protected_adder_pipeline.sv
// Cascade of LAYERS parity-protected adder stages with a sticky error checker.
// Latency: LAYERS cycles from input_vector/in_valid to sum/sum_valid.
// Backpressure: none; a held stage freezes and the upstream stage overwrites its own contents.
module protected_adder_pipeline
    import protected_adder_pipeline_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LAYERS = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       input_vector,
    input  logic                   in_valid,
    input  logic [LAYERS-1:0]      hold_signals,
    input  logic [LAYERS-1:0]      inject,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       sum,
    output logic                   sum_valid,
    output logic [LAYERS-1:0]      error_signals,
    output logic                   Err_out_Final,
    output logic [ERR_LAYER_W-1:0] err_layer,
    output logic [CNT_W-1:0]       err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Index k here is stage k+1: a_q[k]/b_q[k]/v_q[k] are its stored words and valid bit.
    logic [WIDTH-1:0]  a_q [LAYERS];
    logic [WIDTH-1:0]  b_q [LAYERS];
    logic [LAYERS-1:0] a_mis;
    logic [LAYERS-1:0] b_mis;
    logic [LAYERS-1:0] v_q;
    logic [LAYERS:0]   v_chain;

    for (genvar k = 0; k < LAYERS; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;

        // Stage 0 presents the input as both operands.
        if (k == 0) begin : g_first
            assign a_in = input_vector + input_vector;
            assign b_in = input_vector;
        end else begin : g_rest
            assign a_in = a_q[k-1] + b_q[k-1];
            assign b_in = b_q[k-1];
        end

        parity_stage_reg #(.WIDTH(WIDTH)) u_a_reg (
            .clk      (clk),
            .rst_n    (rst_n),
            .hold     (hold_signals[k]),
            .inject   (inject[k]),
            .d        (a_in),
            .q        (a_q[k]),
            .mismatch (a_mis[k])
        );

        // Only the running sum word is subject to fault injection.
        parity_stage_reg #(.WIDTH(WIDTH)) u_b_reg (
            .clk      (clk),
            .rst_n    (rst_n),
            .hold     (hold_signals[k]),
            .inject   (1'b0),
            .d        (b_in),
            .q        (b_q[k]),
            .mismatch (b_mis[k])
        );
    end

    assign v_chain = {v_q, in_valid};

    // Valid bits travel with their words and honour the same per-stage hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k < LAYERS; k++) begin
                if (!hold_signals[k]) begin
                    v_q[k] <= v_chain[k];
                end
            end
        end
    end

    assign error_signals = a_mis | b_mis;
    assign sum           = a_q[LAYERS-1];
    assign sum_valid     = v_q[LAYERS-1];

    logic                   any_err;
    logic [ERR_LAYER_W-1:0] low_idx;

    // Lowest erroring stage index; scanning downwards lets the lowest hit win.
    always_comb begin
        low_idx = '0;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (error_signals[i]) begin
                low_idx = ERR_LAYER_W'(i);
            end
        end
        any_err = |error_signals;
    end

    // Sticky alarm, first-error location and saturating error-cycle counter.
    // A clear restarts the record from the current cycle's error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Err_out_Final <= 1'b0;
            err_layer     <= '0;
            err_count     <= '0;
        end else if (err_clr) begin
            Err_out_Final <= any_err;
            err_layer     <= any_err ? low_idx : '0;
            err_count     <= any_err ? CNT_W'(1) : '0;
        end else begin
            if (any_err && !Err_out_Final) begin
                Err_out_Final <= 1'b1;
                err_layer     <= low_idx;
            end
            if (any_err && err_count != CNT_MAX) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_protected_adder_pipeline.sv
module tb_protected_adder_pipeline;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] input_vector;
    logic       in_valid;
    logic [3:0] hold_signals;
    logic [3:0] inject;
    logic       err_clr;
    logic [7:0] sum;
    logic       sum_valid;
    logic [3:0] error_signals;
    logic       Err_out_Final;
    logic [3:0] err_layer;
    logic [7:0] err_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference history of accepted inputs for the unheld flow.
    bit         hist_v [$];
    logic [7:0] hist_x [$];

    protected_adder_pipeline #(.WIDTH(8), .LAYERS(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .input_vector  (input_vector),
        .in_valid      (in_valid),
        .hold_signals  (hold_signals),
        .inject        (inject),
        .err_clr       (err_clr),
        .sum           (sum),
        .sum_valid     (sum_valid),
        .error_signals (error_signals),
        .Err_out_Final (Err_out_Final),
        .err_layer     (err_layer),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " sum"}, 32'(sum), 0);
        check({tag, " sum_valid"}, 32'(sum_valid), 0);
        check({tag, " error_signals"}, 32'(error_signals), 0);
        check({tag, " Err_out_Final"}, 32'(Err_out_Final), 0);
        check({tag, " err_layer"}, 32'(err_layer), 0);
        check({tag, " err_count"}, 32'(err_count), 0);
    endtask

    // One unheld cycle: output is (LAYERS+1)*x of the input taken LAYERS edges earlier.
    task automatic flow(input bit v, input logic [7:0] x);
        bit         ev;
        logic [7:0] ex;
        in_valid     = v;
        input_vector = x;
        step();
        hist_v.push_back(v);
        hist_x.push_back(x);
        ev = 1'b0;
        ex = 8'd0;
        if (hist_v.size() >= 4) begin
            ev = hist_v[hist_v.size() - 4];
            ex = 8'(5 * int'(hist_x[hist_x.size() - 4]));
        end
        check("flow sum_valid", 32'(sum_valid), 32'(ev));
        if (ev) check("flow sum", 32'(sum), 32'(ex));
        check("flow error_signals", 32'(error_signals), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        input_vector = 8'd0;
        in_valid     = 1'b0;
        hold_signals = 4'd0;
        inject       = 4'd0;
        err_clr      = 1'b0;
        #3;
        check_all_zero("reset");
        #10;
        rst_n = 1'b1;

        // Single words, including the wrap case 5*60 = 300 -> 44.
        flow(1'b1, 8'd3);
        repeat (3) flow(1'b0, 8'd0);
        check("basic sum 15", 32'(sum), 32'd15);
        flow(1'b1, 8'd60);
        repeat (3) flow(1'b0, 8'd0);
        check("wrap sum 44", 32'(sum), 32'd44);
        check("clean no alarm", 32'(Err_out_Final), 0);

        // Random stream, then drain with zeros.
        for (int i = 0; i < 30; i++) flow(1'($urandom_range(0, 1)), 8'($urandom));
        repeat (4) flow(1'b0, 8'd0);

        // Word 7 enters at edge 1 and sits in stage 2 after edge 2; stage 2 is held for
        // edges 3..5, so stage 3 keeps resampling it and 35 is presented after edges 4..7.
        for (int n = 1; n <= 9; n++) begin
            in_valid     = (n == 1);
            input_vector = (n == 1) ? 8'd7 : 8'd0;
            hold_signals = (n >= 3 && n <= 5) ? 4'b0010 : 4'b0000;
            step();
            check("hold sum_valid", 32'(sum_valid), 32'(n >= 4 && n <= 7));
            if (n >= 4 && n <= 7) check("hold sum", 32'(sum), 32'd35);
            check("hold error_signals", 32'(error_signals), 0);
        end
        in_valid     = 1'b0;
        input_vector = 8'd0;
        hold_signals = 4'd0;

        // Fault in stage 3, then keep stage 3 held so the bad word persists.
        inject = 4'b0100;
        step();
        check("inj error_signals", 32'(error_signals), 32'b0100);
        check("inj alarm not yet", 32'(Err_out_Final), 0);
        check("inj count not yet", 32'(err_count), 0);
        inject       = 4'd0;
        hold_signals = 4'b0100;
        for (int n = 2; n <= 4; n++) begin
            step();
            check("inj held error_signals", 32'(error_signals), 32'b0100);
            check("inj Err_out_Final", 32'(Err_out_Final), 1);
            check("inj err_layer", 32'(err_layer), 2);
            check("inj err_count", 32'(err_count), 32'(n - 1));
        end
        hold_signals = 4'd0;
        step();
        check("recapture error_signals", 32'(error_signals), 0);
        check("recapture err_count", 32'(err_count), 4);
        check("sticky alarm", 32'(Err_out_Final), 1);
        check("sticky err_layer", 32'(err_layer), 2);
        step();
        check("idle err_count", 32'(err_count), 4);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr Err_out_Final", 32'(Err_out_Final), 0);
        check("clr err_layer", 32'(err_layer), 0);
        check("clr err_count", 32'(err_count), 0);

        // Faults in stages 2 and 4: lowest wins; clear during a live error restarts at 1.
        inject = 4'b1010;
        step();
        check("dual error_signals", 32'(error_signals), 32'b1010);
        inject       = 4'd0;
        hold_signals = 4'b1010;
        step();
        check("dual Err_out_Final", 32'(Err_out_Final), 1);
        check("dual err_layer", 32'(err_layer), 1);
        check("dual err_count", 32'(err_count), 1);
        err_clr = 1'b1;
        step();
        check("live clr Err_out_Final", 32'(Err_out_Final), 1);
        check("live clr err_layer", 32'(err_layer), 1);
        check("live clr err_count", 32'(err_count), 1);
        err_clr      = 1'b0;
        hold_signals = 4'd0;
        step();
        check("dual recapture error_signals", 32'(error_signals), 0);
        check("dual recapture err_count", 32'(err_count), 2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("dual clr Err_out_Final", 32'(Err_out_Final), 0);
        check("dual clr err_count", 32'(err_count), 0);

        // Saturation: a held fault in stage 1 for 260 edges pins the counter at 255.
        inject = 4'b0001;
        step();
        inject       = 4'd0;
        hold_signals = 4'b0001;
        repeat (260) step();
        check("sat err_count", 32'(err_count), 255);
        check("sat err_layer", 32'(err_layer), 0);
        check("sat error_signals", 32'(error_signals), 32'b0001);

        // Mid-flow asynchronous reset between edges.
        hold_signals = 4'd0;
        in_valid     = 1'b1;
        input_vector = 8'($urandom);
        step();
        input_vector = 8'($urandom);
        step();
        check("pre-reset err_count", 32'(err_count), 255);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_all_zero("async reset");
        #3;
        rst_n = 1'b1;

        // First valid word after release emerges exactly four edges later.
        for (int n = 1; n <= 4; n++) begin
            in_valid     = (n == 1);
            input_vector = (n == 1) ? 8'd9 : 8'd0;
            step();
            check("post-reset sum_valid", 32'(sum_valid), 32'(n == 4));
        end
        check("post-reset sum", 32'(sum), 32'd45);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
